datapath_sequencer: RTL and testbench

//  Microprogrammed control unit that drives the MxN register-file datapath. It holds a writable

---
 rtl/datapath_sequencer.sv | 139 +++++++++++++
 tb/tb_datapath_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Microprogrammed sequencer for the MxN register-file datapath: a writable microstore,
// one microinstruction per clock, flag-conditional branching and a RUN-cycle watchdog.
module datapath_sequencer #(
    parameter int N          = 8,
    parameter int UA         = 5,
    parameter int START_ADDR = 0,
    parameter int MAX_CYCLES = 1024,
    localparam int W         = N + 13 + UA
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          prog_we,
    input  logic [UA-1:0] prog_addr,
    input  logic [W-1:0]  prog_data,
    input  logic          fov,
    input  logic          fcarry,
    input  logic          fneg,
    input  logic          fzero,
    output logic [N-1:0]  writer,
    output logic [2:0]    selection_multa,
    output logic [2:0]    selection_multb,
    output logic [1:0]    selection_alu,
    output logic [1:0]    selection_sr,
    output logic [UA-1:0] upc,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    state_dbg
);

    // start and prog_we are level-qualified strobes with no ready: start is honoured only
    // in IDLE/HALT, prog_we only outside RUN; anything else is silently dropped.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(MAX_CYCLES - 1);

    state_t          state, state_next;
    logic [UA-1:0]   upc_next;
    logic [15:0]     count, count_next;
    logic            err_next;
    logic [W-1:0]    store [2**UA];
    logic [W-1:0]    word;
    logic [2:0]      cond;
    logic [UA-1:0]   target;
    logic            take;

    always_ff @(posedge clk) begin
        if (prog_we && state != RUN)
            store[prog_addr] <= prog_data;
    end

    assign word   = store[upc];
    assign cond   = word[UA+2:UA];
    assign target = word[UA-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            upc   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            upc   <= upc_next;
            count <= count_next;
            err   <= err_next;
        end
    end

    always_comb begin
        take = 1'b0;
        case (cond)
            3'b001:  take = 1'b1;
            3'b010:  take = fzero;
            3'b011:  take = fneg;
            3'b100:  take = fcarry;
            3'b101:  take = fov;
            3'b110:  take = !fzero;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        upc_next   = upc;
        count_next = count;
        err_next   = err;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_next = RUN;
                    upc_next   = UA'(START_ADDR);
                    count_next = '0;
                    err_next   = 1'b0;
                end
            end
            RUN: begin
                count_next = count + 16'd1;
                if (cond == 3'b111) begin
                    state_next = HALT;
                end else begin
                    upc_next = take ? target : upc + UA'(1);
                    // Watchdog aborts after the current word has executed.
                    if (MAX_CYCLES != 0 && count == WD_LAST) begin
                        state_next = HALT;
                        err_next   = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        writer          = '0;
        selection_multa = '0;
        selection_multb = '0;
        selection_alu   = '0;
        selection_sr    = '0;
        if (state == RUN) begin
            writer          = word[W-1:UA+13];
            selection_multa = word[UA+12:UA+10];
            selection_multb = word[UA+9:UA+7];
            selection_alu   = word[UA+6:UA+5];
            selection_sr    = word[UA+4:UA+3];
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: three instances (default, START_ADDR=31,
// MAX_CYCLES=8) share the programming port and reset, each with its own start.
module tb_datapath_sequencer;

    localparam int N  = 8;
    localparam int UA = 5;
    localparam int W  = N + 13 + UA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          start_a = 1'b0, start_w = 1'b0, start_d = 1'b0;
    logic          prog_we = 1'b0;
    logic [UA-1:0] prog_addr = '0;
    logic [W-1:0]  prog_data = '0;
    logic          fov = 1'b0, fcarry = 1'b0, fneg = 1'b0, fzero = 1'b0;

    logic [N-1:0]  a_writer, w_writer, d_writer;
    logic [2:0]    a_multa, a_multb, w_multa, w_multb, d_multa, d_multb;
    logic [1:0]    a_alu, a_sr, w_alu, w_sr, d_alu, d_sr;
    logic [UA-1:0] a_upc, w_upc, d_upc;
    logic          a_busy, a_done, a_err, w_busy, w_done, w_err, d_busy, d_done, d_err;
    logic [1:0]    a_state, w_state, d_state;

    int tests = 0;
    int fails = 0;

    datapath_sequencer #(.N(N), .UA(UA), .START_ADDR(0), .MAX_CYCLES(1024)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .fov(fov), .fcarry(fcarry), .fneg(fneg), .fzero(fzero),
        .writer(a_writer), .selection_multa(a_multa), .selection_multb(a_multb),
        .selection_alu(a_alu), .selection_sr(a_sr), .upc(a_upc), .busy(a_busy),
        .done(a_done), .err(a_err), .state_dbg(a_state)
    );

    datapath_sequencer #(.N(N), .UA(UA), .START_ADDR(31), .MAX_CYCLES(1024)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .fov(fov), .fcarry(fcarry), .fneg(fneg), .fzero(fzero),
        .writer(w_writer), .selection_multa(w_multa), .selection_multb(w_multb),
        .selection_alu(w_alu), .selection_sr(w_sr), .upc(w_upc), .busy(w_busy),
        .done(w_done), .err(w_err), .state_dbg(w_state)
    );

    datapath_sequencer #(.N(N), .UA(UA), .START_ADDR(0), .MAX_CYCLES(8)) dut_d (
        .clk(clk), .rst(rst), .start(start_d), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .fov(fov), .fcarry(fcarry), .fneg(fneg), .fzero(fzero),
        .writer(d_writer), .selection_multa(d_multa), .selection_multb(d_multb),
        .selection_alu(d_alu), .selection_sr(d_sr), .upc(d_upc), .busy(d_busy),
        .done(d_done), .err(d_err), .state_dbg(d_state)
    );

    function automatic logic [W-1:0] mk(input logic [7:0] wr, input logic [2:0] ma,
                                        input logic [2:0] mb, input logic [1:0] al,
                                        input logic [1:0] s, input logic [2:0] c,
                                        input logic [4:0] t);
        return {wr, ma, mb, al, s, c, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [UA-1:0] addr, input logic [W-1:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        prog(5'd0, mk(8'hFF, 3'd7, 3'd7, 2'd3, 2'd3, 3'd0, 5'd0));
        start_a = 1'b1;
        rst = 1'b0;
        tick();
        if ({a_writer, a_multa, a_multb, a_alu, a_sr} !== '0) begin
            $display("FAIL reset_ctrl got=%h want=0", {a_writer, a_multa, a_multb, a_alu, a_sr});
            fails++;
        end
        tests++;
        if ({a_upc, a_busy, a_done, a_err} !== '0) begin
            $display("FAIL reset_status upc=%0d busy=%b done=%b err=%b want all 0",
                     a_upc, a_busy, a_done, a_err);
            fails++;
        end
        tests++;
        if (a_state !== 2'd0) begin
            $display("FAIL reset_state got=%0d want=0", a_state);
            fails++;
        end
        tests++;
        start_a = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        logic [7:0] exp_wr [4];
        exp_wr = '{8'h01, 8'h02, 8'h04, 8'h08};
        prog(5'd0, mk(8'h01, 3'd1, 3'd2, 2'd1, 2'd2, 3'd0, 5'd9));
        prog(5'd1, mk(8'h02, 3'd1, 3'd2, 2'd1, 2'd2, 3'd0, 5'd9));
        prog(5'd2, mk(8'h04, 3'd1, 3'd2, 2'd1, 2'd2, 3'd0, 5'd9));
        prog(5'd3, mk(8'h08, 3'd5, 3'd6, 2'd3, 2'd1, 3'd7, 5'd9));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (a_writer !== exp_wr[i] || a_busy !== 1'b1 || a_upc !== UA'(i)) begin
                $display("FAIL seq_step%0d writer=%h busy=%b upc=%0d want writer=%h busy=1 upc=%0d",
                         i, a_writer, a_busy, a_upc, exp_wr[i], i);
                fails++;
            end
            tests++;
            if (i == 3 && {a_multa, a_multb, a_alu, a_sr} !== {3'd5, 3'd6, 2'd3, 2'd1}) begin
                $display("FAIL seq_halt_fields got=%h want=%h",
                         {a_multa, a_multb, a_alu, a_sr}, {3'd5, 3'd6, 2'd3, 2'd1});
                fails++;
            end
            if (i == 3) tests++;
            tick();
        end
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_writer !== 8'h00 || a_upc !== 5'd3) begin
            $display("FAIL seq_halt done=%b busy=%b writer=%h upc=%0d want 1 0 00 3",
                     a_done, a_busy, a_writer, a_upc);
            fails++;
        end
        tests++;
    endtask

    task automatic test_branch();
        int conds [5];
        logic v;
        logic [UA-1:0] exp_upc;
        conds = '{2, 3, 4, 5, 6};
        prog(5'd0, mk(8'h01, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 5'd0));
        prog(5'd2, mk(8'h04, 3'd0, 3'd0, 2'd0, 2'd0, 3'd7, 5'd0));
        prog(5'd5, mk(8'h20, 3'd0, 3'd0, 2'd0, 2'd0, 3'd7, 5'd0));
        for (int k = 0; k < 5; k++) begin
            prog(5'd1, mk(8'h02, 3'd0, 3'd0, 2'd0, 2'd0, 3'(conds[k]), 5'd5));
            for (int t = 1; t >= 0; t--) begin
                v = (conds[k] == 6) ? !t[0] : t[0];
                {fov, fcarry, fneg, fzero} = {4{!v}};
                case (conds[k])
                    2, 6: fzero = v;
                    3: fneg = v;
                    4: fcarry = v;
                    default: fov = v;
                endcase
                exp_upc = t[0] ? 5'd5 : 5'd2;
                start_a = 1'b1;
                tick();
                start_a = 1'b0;
                tick();
                if (a_upc !== 5'd1) begin
                    $display("FAIL br_c%0d_pre upc=%0d want=1", conds[k], a_upc);
                    fails++;
                end
                tests++;
                tick();
                if (a_upc !== exp_upc || a_writer !== (t[0] ? 8'h20 : 8'h04)) begin
                    $display("FAIL br_c%0d_t%0d upc=%0d writer=%h want upc=%0d", conds[k], t,
                             a_upc, a_writer, exp_upc);
                    fails++;
                end
                tests++;
                tick();
            end
        end
        {fov, fcarry, fneg, fzero} = 4'b0000;
    endtask

    task automatic test_wrap();
        prog(5'd31, mk(8'h80, 3'd1, 3'd1, 2'd1, 2'd1, 3'd0, 5'd7));
        prog(5'd0, mk(8'h11, 3'd3, 3'd4, 2'd2, 2'd1, 3'd7, 5'd0));
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        if (w_upc !== 5'd31 || w_writer !== 8'h80) begin
            $display("FAIL wrap_first upc=%0d writer=%h want 31 80", w_upc, w_writer);
            fails++;
        end
        tests++;
        tick();
        if (w_upc !== 5'd0 || {w_writer, w_multa, w_multb, w_alu, w_sr} !==
            {8'h11, 3'd3, 3'd4, 2'd2, 2'd1}) begin
            $display("FAIL wrap_next upc=%0d fields=%h want upc=0 fields=%h", w_upc,
                     {w_writer, w_multa, w_multb, w_alu, w_sr}, {8'h11, 3'd3, 3'd4, 2'd2, 2'd1});
            fails++;
        end
        tests++;
        tick();
        if (w_done !== 1'b1) begin
            $display("FAIL wrap_halt done=%b want=1", w_done);
            fails++;
        end
        tests++;
    endtask

    task automatic test_watchdog();
        prog(5'd0, mk(8'h01, 3'd0, 3'd0, 2'd0, 2'd0, 3'd1, 5'd0));
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (d_busy !== 1'b1 || d_err !== 1'b0 || d_writer !== 8'h01) begin
                $display("FAIL wd_run%0d busy=%b err=%b writer=%h want 1 0 01", i + 1, d_busy,
                         d_err, d_writer);
                fails++;
            end
            tests++;
            tick();
        end
        if (d_done !== 1'b1 || d_err !== 1'b1 || d_busy !== 1'b0 || d_writer !== 8'h00) begin
            $display("FAIL wd_abort done=%b err=%b busy=%b writer=%h want 1 1 0 00", d_done,
                     d_err, d_busy, d_writer);
            fails++;
        end
        tests++;
        tick();
        if (d_err !== 1'b1 || d_done !== 1'b1) begin
            $display("FAIL wd_hold err=%b done=%b want 1 1", d_err, d_done);
            fails++;
        end
        tests++;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        if (d_err !== 1'b0 || d_busy !== 1'b1) begin
            $display("FAIL wd_restart err=%b busy=%b want 0 1", d_err, d_busy);
            fails++;
        end
        tests++;
        for (int i = 0; i < 8; i++) tick();
        if (d_done !== 1'b1 || d_err !== 1'b1) begin
            $display("FAIL wd_again done=%b err=%b want 1 1", d_done, d_err);
            fails++;
        end
        tests++;
    endtask

    task automatic test_midrun();
        prog(5'd0, mk(8'h01, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 5'd0));
        prog(5'd1, mk(8'h02, 3'd0, 3'd0, 2'd0, 2'd0, 3'd0, 5'd0));
        prog(5'd2, mk(8'h04, 3'd0, 3'd0, 2'd0, 2'd0, 3'd7, 5'd0));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        prog(5'd1, mk(8'hFF, 3'd7, 3'd7, 2'd3, 2'd3, 3'd7, 5'd0));
        if (a_writer !== 8'h02 || a_upc !== 5'd1) begin
            $display("FAIL mid_write_run writer=%h upc=%0d want 02 1", a_writer, a_upc);
            fails++;
        end
        tests++;
        tick();
        tick();
        if (a_done !== 1'b1) begin
            $display("FAIL mid_halt done=%b want=1", a_done);
            fails++;
        end
        tests++;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        if (a_writer !== 8'h02 || a_busy !== 1'b1) begin
            $display("FAIL mid_readback writer=%h busy=%b want 02 1", a_writer, a_busy);
            fails++;
        end
        tests++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_upc !== 5'd0 || a_writer !== 8'h00) begin
            $display("FAIL mid_reset busy=%b done=%b upc=%0d writer=%h want 0 0 0 00", a_busy,
                     a_done, a_upc, a_writer);
            fails++;
        end
        tests++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_watchdog();
        test_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
